pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage VeSPA CPU pipeline (IF, DE, EX, MEM, WB).
- Works alongside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, multi-cycle data-memory access, taken branches, and HLT drain.
- Drives the write-enables and flush strobes of the PC and the IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MEM_TIMEOUT, 255, max consecutive un-acked data-memory cycles before fault; 8-bit counter, legal 1..255
DRAIN_CYCLES, 3, cycles to let instructions older than HLT retire before freezing; legal 1..7

Ports:
i_Clk  in  1  system clock, rising edge
i_Rst  in  1  asynchronous, active-high reset
i_RdAddr1Decode  in  5  RF read address 1 of the instruction in DE
i_RdAddr2Decode  in  5  RF read address 2 of the instruction in DE
i_Uses1Decode  in  1  DE instruction really reads address 1
i_Uses2Decode  in  1  DE instruction really reads address 2
i_RfWeExec  in  1  RF write enable of the instruction in EX
i_RfDstExec  in  5  RF destination of the instruction in EX
i_RfDataInSelExec  in  2  RF input-mux select in EX; 2'b01 = data-memory load
i_MemReqMemory  in  1  MEM-stage instruction accesses data memory (LD/ST)
i_MemReady  in  1  data-memory ack, same cycle as completion
i_BranchTakenExec  in  1  branch/jump in EX resolved taken
i_HaltExec  in  1  HLT instruction in EX
i_Resume  in  1  single-cycle pulse to leave HALTED
o_PcWe  out  1  PC update enable
o_IfDeWe  out  1  IF/DE register enable
o_IfDeFlush  out  1  IF/DE register loads NOP
o_DeExWe  out  1  DE/EX register enable
o_DeExFlush  out  1  DE/EX register loads NOP
o_ExMemWe  out  1  EX/MEM register enable
o_MemWbBubble  out  1  MEM/WB register loads NOP (RF write suppressed)
o_Halted  out  1  core frozen
o_MemTimeout  out  1  sticky data-memory timeout fault
o_StallCount  out  16  stall-cycle counter (see Optional Feature)
o_FlushCount  out  16  flush-event counter (see Optional Feature)

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset values: state=RUN, wait counter=0, drain counter=0, o_Halted=0, o_MemTimeout=0, counters=0.
- While i_Rst is high, all *We outputs are 0, and o_IfDeFlush, o_DeExFlush and o_MemWbBubble are 1.
- Defaults (no hazard): every *We=1; flushes and bubble=0.
- MemStall = i_MemReqMemory & ~i_MemReady.
  - Freezes PC, IF/DE, DE/EX and EX/MEM (all *We=0) and asserts o_MemWbBubble. No flush.
  - Combinational, so it applies in the first wait cycle.
- LoadUse = i_RfWeExec & (i_RfDataInSelExec==2'b01) & ((i_Uses1Decode & addr1==dst) | (i_Uses2Decode & addr2==dst)).
  - Gives o_PcWe=0, o_IfDeWe=0, o_DeExFlush=1.
  - Exactly one bubble: on the next cycle the load is in MEM and forwarding covers it.
- BranchTaken: o_IfDeFlush=1 and o_DeExFlush=1 for one cycle; PC loads the target (o_PcWe=1).
- Priority: MemStall > BranchTaken > LoadUse.
  - Branch during MemStall is held, because EX is frozen, and is acted on in the first cycle after i_MemReady.
  - LoadUse coinciding with BranchTaken is ignored, since the consumer is flushed.
- Register 0 is not special-cased.
- RUN -> MEM_WAIT when MemStall. The wait counter increments every MemStall cycle.
- MEM_WAIT -> RUN on the cycle i_MemReady=1; the counter clears.
- In MEM_WAIT, when the counter reaches MEM_TIMEOUT with MemStall still true:
  - next state is HALTED;
  - o_MemTimeout is set and stays set until reset.
- RUN -> DRAIN when i_HaltExec and no MemStall.
  - Same cycle: flush IF/DE and DE/EX, and PC stops (o_PcWe=0).
  - In DRAIN: PC and IF/DE frozen, DE/EX flushed each cycle, EX/MEM and MEM/WB run normally.
  - The drain counter counts DRAIN_CYCLES, then the state goes to HALTED.
  - MemStall during DRAIN freezes as above and pauses the drain counter.
- HALTED: all *We=0, o_MemWbBubble=1, o_Halted=1. i_Resume -> RUN next cycle, o_Halted=0.
  - i_Resume has no effect in other states.
  - i_Resume does not clear o_MemTimeout.
- Reset asserted mid-operation returns immediately to reset values regardless of state.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - o_StallCount increments every cycle with MemStall, LoadUse or state DRAIN.
  - o_FlushCount increments on each BranchTaken flush.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared only by reset.
- Not defined: both ports are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Load-use: LD r3 in EX (dst=3, sel=2'b01, we=1), DE reads r3 with uses1=1 -> one cycle of o_PcWe=0, o_IfDeWe=0, o_DeExFlush=1, then defaults. Same case with uses1=0 -> no stall.
- Memory wait: i_MemReqMemory=1, i_MemReady low for 4 cycles then high -> 4 cycles of all *We=0 and bubble=1, state MEM_WAIT, then RUN; o_MemTimeout=0.
- Timeout (MEM_TIMEOUT=4): i_MemReady never asserted -> HALTED after the 4th wait cycle; o_MemTimeout=1 and o_Halted=1 persist after an i_Resume pulse.
- Branch during stall: i_BranchTakenExec=1 together with a 2-cycle MemStall -> no flush for 2 cycles, then one cycle with o_IfDeFlush=o_DeExFlush=1.
- Halt: i_HaltExec=1 (DRAIN_CYCLES=3) -> 3 DRAIN cycles with EX/MEM enabled, then o_Halted=1. i_Resume pulse -> RUN with o_Halted=0 next cycle. Async i_Rst mid-DRAIN -> immediate reset values.
- With HAZARD_PERF_CNT_EN: after the load-use plus 4-cycle wait scenarios, o_StallCount=5 and o_FlushCount=0. Without the macro, both read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for the 5-stage VeSPA pipeline (IF, DE, EX, MEM, WB).
// It handles the hazards that forwarding cannot resolve:
//   - load-use
//   - multi-cycle data-memory access
//   - taken branches
//   - HLT drain
//
// Parameters:
//   MEM_TIMEOUT   consecutive un-acked data-memory cycles before a fault (1..255)
//   DRAIN_CYCLES  cycles granted to older instructions after HLT (1..7)
//
// Optional feature:
//   HAZARD_PERF_CNT_EN  when defined, builds saturating 16-bit stall and flush
//                       counters. When undefined, both counter ports read 0.
//
// Ports:
//   i_Clk, i_Rst           clock (rising edge), async active-high reset
//   i_RdAddr1/2Decode      RF read addresses of the DE instruction
//   i_Uses1/2Decode        DE instruction really reads that address
//   i_RfWeExec, i_RfDstExec, i_RfDataInSelExec
//                          RF write info of the EX instruction (sel 01 = load)
//   i_MemReqMemory         MEM instruction accesses data memory
//   i_MemReady             data-memory ack
//   i_BranchTakenExec      taken branch/jump in EX
//   i_HaltExec             HLT in EX
//   i_Resume               pulse that leaves HALTED
//   o_PcWe, o_IfDeWe, o_DeExWe, o_ExMemWe
//                          pipeline register enables
//   o_IfDeFlush, o_DeExFlush, o_MemWbBubble
//                          NOP-insert strobes
//   o_Halted, o_MemTimeout core frozen / sticky memory timeout fault
//   o_StallCount, o_FlushCount
//                          performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [4:0]  i_RdAddr1Decode,
    input  logic [4:0]  i_RdAddr2Decode,
    input  logic        i_Uses1Decode,
    input  logic        i_Uses2Decode,
    input  logic        i_RfWeExec,
    input  logic [4:0]  i_RfDstExec,
    input  logic [1:0]  i_RfDataInSelExec,
    input  logic        i_MemReqMemory,
    input  logic        i_MemReady,
    input  logic        i_BranchTakenExec,
    input  logic        i_HaltExec,
    input  logic        i_Resume,
    output logic        o_PcWe,
    output logic        o_IfDeWe,
    output logic        o_IfDeFlush,
    output logic        o_DeExWe,
    output logic        o_DeExFlush,
    output logic        o_ExMemWe,
    output logic        o_MemWbBubble,
    output logic        o_Halted,
    output logic        o_MemTimeout,
    output logic [15:0] o_StallCount,
    output logic [15:0] o_FlushCount
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    // The wait counter is compared against MEM_TIMEOUT-1 because the
    // comparison is made before the increment of the current wait cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] DRAIN_LAST   = 3'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic [2:0]  r_drain_cnt;
    logic [2:0]  w_drain_cnt_nxt;
    logic        r_mem_timeout;
    logic        w_timeout_set;

    logic        w_mem_stall;
    logic        w_load_use;
    logic        w_pc_we;
    logic        w_ifde_we;
    logic        w_ifde_flush;
    logic        w_deex_we;
    logic        w_deex_flush;
    logic        w_exmem_we;
    logic        w_memwb_bubble;

    // Hazard detection from the raw stage information.
    assign w_mem_stall = i_MemReqMemory & ~i_MemReady;
    assign w_load_use  = i_RfWeExec & (i_RfDataInSelExec == 2'b01) &
                         ((i_Uses1Decode & (i_RdAddr1Decode == i_RfDstExec)) |
                          (i_Uses2Decode & (i_RdAddr2Decode == i_RfDstExec)));

    // State, wait/drain counters and the sticky timeout flag.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_drain_cnt   <= 3'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_mem_timeout <= r_mem_timeout | w_timeout_set;
        end
    end

    // Next-state and pipeline control decode.
    // MemStall outranks everything: the whole front of the pipe is frozen,
    // so a branch or load-use in EX/DE is simply held until memory acks.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = 8'd0;
        w_drain_cnt_nxt = r_drain_cnt;
        w_timeout_set   = 1'b0;
        w_pc_we         = 1'b1;
        w_ifde_we       = 1'b1;
        w_ifde_flush    = 1'b0;
        w_deex_we       = 1'b1;
        w_deex_flush    = 1'b0;
        w_exmem_we      = 1'b1;
        w_memwb_bubble  = 1'b0;

        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_pc_we        = 1'b0;
                    w_ifde_we      = 1'b0;
                    w_deex_we      = 1'b0;
                    w_exmem_we     = 1'b0;
                    w_memwb_bubble = 1'b1;
                    if (r_wait_cnt >= TIMEOUT_LAST) begin
                        w_state_nxt    = ST_HALTED;
                        w_timeout_set  = 1'b1;
                        w_wait_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt    = ST_MEM_WAIT;
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else if (i_HaltExec) begin
                    // Squash everything younger than HLT and stop fetching.
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = 3'd0;
                    w_pc_we         = 1'b0;
                    w_ifde_flush    = 1'b1;
                    w_deex_flush    = 1'b1;
                end else if (i_BranchTakenExec) begin
                    // A load-use at the same time is moot: its consumer is flushed.
                    w_state_nxt  = ST_RUN;
                    w_ifde_flush = 1'b1;
                    w_deex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_state_nxt  = ST_RUN;
                    w_pc_we      = 1'b0;
                    w_ifde_we    = 1'b0;
                    w_deex_flush = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (w_mem_stall) begin
                    // Freeze and pause the drain count while memory is busy.
                    w_pc_we        = 1'b0;
                    w_ifde_we      = 1'b0;
                    w_deex_we      = 1'b0;
                    w_exmem_we     = 1'b0;
                    w_memwb_bubble = 1'b1;
                    if (r_wait_cnt >= TIMEOUT_LAST) begin
                        w_state_nxt    = ST_HALTED;
                        w_timeout_set  = 1'b1;
                        w_wait_cnt_nxt = 8'd0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    w_pc_we      = 1'b0;
                    w_ifde_we    = 1'b0;
                    w_deex_flush = 1'b1;
                    if (r_drain_cnt >= DRAIN_LAST) begin
                        w_state_nxt     = ST_HALTED;
                        w_drain_cnt_nxt = 3'd0;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + 3'd1;
                    end
                end
            end

            ST_HALTED: begin
                w_pc_we        = 1'b0;
                w_ifde_we      = 1'b0;
                w_deex_we      = 1'b0;
                w_exmem_we     = 1'b0;
                w_memwb_bubble = 1'b1;
                // A timeout fault keeps the core frozen until reset.
                if (i_Resume && !r_mem_timeout) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end

            default: begin
                w_state_nxt     = ST_RUN;
                w_drain_cnt_nxt = 3'd0;
                w_pc_we         = 1'b0;
                w_ifde_we       = 1'b0;
                w_deex_we       = 1'b0;
                w_exmem_we      = 1'b0;
                w_memwb_bubble  = 1'b1;
            end
        endcase
    end

    // Reset forces every stage to hold and inject NOPs.
    assign o_PcWe        = i_Rst ? 1'b0 : w_pc_we;
    assign o_IfDeWe      = i_Rst ? 1'b0 : w_ifde_we;
    assign o_IfDeFlush   = i_Rst ? 1'b1 : w_ifde_flush;
    assign o_DeExWe      = i_Rst ? 1'b0 : w_deex_we;
    assign o_DeExFlush   = i_Rst ? 1'b1 : w_deex_flush;
    assign o_ExMemWe     = i_Rst ? 1'b0 : w_exmem_we;
    assign o_MemWbBubble = i_Rst ? 1'b1 : w_memwb_bubble;
    assign o_Halted      = (r_state == ST_HALTED);
    assign o_MemTimeout  = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_stall_evt = w_mem_stall | w_load_use | (r_state == ST_DRAIN);
    // Mirrors the branch-flush decode above: RUN/MEM_WAIT, no stall, no HLT.
    assign w_flush_evt = i_BranchTakenExec & ~w_mem_stall & ~i_HaltExec &
                         ((r_state == ST_RUN) | (r_state == ST_MEM_WAIT));

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'h0001;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign o_StallCount = r_stall_cnt;
    assign o_FlushCount = r_flush_cnt;
`else
    assign o_StallCount = 16'h0000;
    assign o_FlushCount = 16'h0000;
`endif

endmodule
